// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with rename busy/tag, N read ports and branch checkpoints.
// Optional build macro REG_COMMIT_BYPASS_EN forwards same-cycle commit data to busy read ports.
module reg_status_file #(
    parameter int NUM_REGS   = 32,
    parameter int XLEN       = 32,
    parameter int ROB_BIT    = 4,
    parameter int READ_PORTS = 2,
    parameter int CKPT_DEPTH = 4,
    localparam int REG_BIT   = $clog2(NUM_REGS),
    localparam int CKPT_BIT  = $clog2(CKPT_DEPTH),
    localparam int CNT_BIT   = CKPT_BIT + 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          rob_clear_up,
    input  logic                          rob_commit,
    input  logic [REG_BIT-1:0]            commit_reg_id,
    input  logic [XLEN-1:0]               commit_reg_data,
    input  logic [ROB_BIT-1:0]            commit_rob_entry,
    input  logic                          issue_pollute,
    input  logic [REG_BIT-1:0]            issue_reg_id,
    input  logic [ROB_BIT-1:0]            issue_rob_entry,
    input  logic [READ_PORTS*REG_BIT-1:0] get_id,
    output logic [READ_PORTS*XLEN-1:0]    val,
    output logic [READ_PORTS-1:0]         has_dep,
    output logic [READ_PORTS*ROB_BIT-1:0] dep,
    output logic [READ_PORTS*ROB_BIT-1:0] get_rob_entry,
    input  logic [READ_PORTS-1:0]         ready,
    input  logic [READ_PORTS*XLEN-1:0]    value,
    input  logic                          ckpt_take,
    output logic [CKPT_BIT-1:0]           ckpt_id,
    input  logic                          ckpt_restore,
    input  logic [CKPT_BIT-1:0]           ckpt_restore_id,
    input  logic                          ckpt_release,
    output logic                          ckpt_full,
    output logic                          ckpt_ovf
);

    logic [XLEN-1:0]                             regs [NUM_REGS];
    logic [NUM_REGS-1:0]                         busy, busy_nx;
    logic [NUM_REGS-1:0][ROB_BIT-1:0]            tag, tag_nx;
    logic [CKPT_DEPTH-1:0][NUM_REGS-1:0]         ckpt_busy, ckpt_busy_nx;
    logic [CKPT_DEPTH-1:0][NUM_REGS-1:0][ROB_BIT-1:0] ckpt_tag, ckpt_tag_nx;
    logic [CKPT_BIT-1:0]                         head, head_nx, tail, tail_nx;
    logic [CNT_BIT-1:0]                          count, count_nx;
    logic                                        ovf_nx;
    logic [CKPT_DEPTH-1:0]                       live;
    logic                                        commit_en, issue_en, take_ok;
    logic [CKPT_BIT-1:0]                         restore_off;
    logic [REG_BIT-1:0]                          rd_id [READ_PORTS];

    assign commit_en   = rob_commit && (commit_reg_id != '0);
    assign issue_en    = issue_pollute && (issue_reg_id != '0);
    assign ckpt_full   = (count == CNT_BIT'(CKPT_DEPTH));
    assign take_ok     = ckpt_take && (!ckpt_full || ckpt_release);
    assign restore_off = ckpt_restore_id - head;
    assign ckpt_id     = tail;

    // A slot is live when its distance from head (mod depth) is below count.
    always_comb begin
        live = '0;
        for (int unsigned s = 0; s < CKPT_DEPTH; s++) begin
            live[s] = {1'b0, CKPT_BIT'(s) - head} < count;
        end
    end

    always_comb begin
        busy_nx      = busy;
        tag_nx       = tag;
        ckpt_busy_nx = ckpt_busy;
        ckpt_tag_nx  = ckpt_tag;
        head_nx      = head;
        tail_nx      = tail;
        count_nx     = count;
        ovf_nx       = ckpt_ovf;
        if (rob_clear_up) begin
            busy_nx  = '0;
            tag_nx   = '0;
            head_nx  = '0;
            tail_nx  = '0;
            count_nx = '0;
        end else begin
            if (commit_en) begin
                for (int unsigned s = 0; s < CKPT_DEPTH; s++) begin
                    if (live[s] && ckpt_tag[s][commit_reg_id] == commit_rob_entry) begin
                        ckpt_busy_nx[s][commit_reg_id] = 1'b0;
                        ckpt_tag_nx[s][commit_reg_id]  = '0;
                    end
                end
            end
            if (ckpt_restore) begin
                busy_nx = ckpt_busy[ckpt_restore_id];
                tag_nx  = ckpt_tag[ckpt_restore_id];
                if (commit_en && ckpt_tag[ckpt_restore_id][commit_reg_id] == commit_rob_entry) begin
                    busy_nx[commit_reg_id] = 1'b0;
                    tag_nx[commit_reg_id]  = '0;
                end
                tail_nx  = ckpt_restore_id + CKPT_BIT'(1);
                head_nx  = head + CKPT_BIT'(ckpt_release);
                count_nx = CNT_BIT'(restore_off) + CNT_BIT'(1) - CNT_BIT'(ckpt_release);
            end else begin
                if (commit_en && tag[commit_reg_id] == commit_rob_entry) begin
                    busy_nx[commit_reg_id] = 1'b0;
                    tag_nx[commit_reg_id]  = '0;
                end
                if (issue_en) begin
                    busy_nx[issue_reg_id] = 1'b1;
                    tag_nx[issue_reg_id]  = issue_rob_entry;
                end
                // Snapshot is written after the commit clear so the fresh copy wins on slot reuse.
                if (take_ok) begin
                    ckpt_busy_nx[tail] = busy_nx;
                    ckpt_tag_nx[tail]  = tag_nx;
                    tail_nx            = tail + CKPT_BIT'(1);
                end else if (ckpt_take) begin
                    ovf_nx = 1'b1;
                end
                head_nx  = head + CKPT_BIT'(ckpt_release);
                count_nx = count + CNT_BIT'(take_ok) - CNT_BIT'(ckpt_release);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy      <= '0;
            tag       <= '0;
            ckpt_busy <= '0;
            ckpt_tag  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ckpt_ovf  <= 1'b0;
        end else if (rdy_in) begin
            if (commit_en && !rob_clear_up) begin
                regs[commit_reg_id] <= commit_reg_data;
            end
            busy      <= busy_nx;
            tag       <= tag_nx;
            ckpt_busy <= ckpt_busy_nx;
            ckpt_tag  <= ckpt_tag_nx;
            head      <= head_nx;
            tail      <= tail_nx;
            count     <= count_nx;
            ckpt_ovf  <= ovf_nx;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            rd_id[p] = get_id[p*REG_BIT +: REG_BIT];
        end
    end

    always_comb begin
        val     = '0;
        has_dep = '0;
        dep     = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            if (rd_id[p] != '0) begin
                if (busy[rd_id[p]]) begin
                    dep[p*ROB_BIT +: ROB_BIT] = tag[rd_id[p]];
                    has_dep[p]                = !ready[p];
                    val[p*XLEN +: XLEN]       = value[p*XLEN +: XLEN];
`ifdef REG_COMMIT_BYPASS_EN
                    if (rob_commit && tag[rd_id[p]] == commit_rob_entry) begin
                        has_dep[p]          = 1'b0;
                        val[p*XLEN +: XLEN] = commit_reg_data;
                    end
`endif
                end else begin
                    val[p*XLEN +: XLEN] = regs[rd_id[p]];
                end
            end
        end
    end

    assign get_rob_entry = dep;

endmodule

// File: tb/tb_reg_status_file.sv
// Directed self-checking bench for reg_status_file: rename, commit, checkpoints, flush and stall.
module tb_reg_status_file;

    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;
    localparam int ROB_BIT    = 4;
    localparam int READ_PORTS = 2;
    localparam int CKPT_DEPTH = 4;
    localparam int REG_BIT    = 5;
    localparam int CKPT_BIT   = 2;

    logic                          clk_in = 1'b0;
    logic                          rst_in, rdy_in, rob_clear_up, rob_commit;
    logic [REG_BIT-1:0]            commit_reg_id;
    logic [XLEN-1:0]               commit_reg_data;
    logic [ROB_BIT-1:0]            commit_rob_entry;
    logic                          issue_pollute;
    logic [REG_BIT-1:0]            issue_reg_id;
    logic [ROB_BIT-1:0]            issue_rob_entry;
    logic [READ_PORTS*REG_BIT-1:0] get_id;
    logic [READ_PORTS*XLEN-1:0]    val;
    logic [READ_PORTS-1:0]         has_dep;
    logic [READ_PORTS*ROB_BIT-1:0] dep, get_rob_entry;
    logic [READ_PORTS-1:0]         ready;
    logic [READ_PORTS*XLEN-1:0]    value;
    logic                          ckpt_take, ckpt_restore, ckpt_release;
    logic [CKPT_BIT-1:0]           ckpt_id, ckpt_restore_id;
    logic                          ckpt_full, ckpt_ovf;

    int tests = 0;
    int fails = 0;

    reg_status_file #(
        .NUM_REGS(NUM_REGS), .XLEN(XLEN), .ROB_BIT(ROB_BIT),
        .READ_PORTS(READ_PORTS), .CKPT_DEPTH(CKPT_DEPTH)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
        .rob_commit(rob_commit), .commit_reg_id(commit_reg_id), .commit_reg_data(commit_reg_data),
        .commit_rob_entry(commit_rob_entry), .issue_pollute(issue_pollute),
        .issue_reg_id(issue_reg_id), .issue_rob_entry(issue_rob_entry), .get_id(get_id),
        .val(val), .has_dep(has_dep), .dep(dep), .get_rob_entry(get_rob_entry),
        .ready(ready), .value(value), .ckpt_take(ckpt_take), .ckpt_id(ckpt_id),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
        .ckpt_release(ckpt_release), .ckpt_full(ckpt_full), .ckpt_ovf(ckpt_ovf)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; rob_clear_up = 1'b0; rob_commit = 1'b0;
        commit_reg_id = '0; commit_reg_data = '0; commit_rob_entry = '0;
        issue_pollute = 1'b0; issue_reg_id = '0; issue_rob_entry = '0;
        ready = '0; value = '0;
        ckpt_take = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0; ckpt_release = 1'b0;
    endtask

    task automatic rd(input int p, input logic [REG_BIT-1:0] id);
        get_id[p*REG_BIT +: REG_BIT] = id;
    endtask

    task automatic issue(input logic [REG_BIT-1:0] id, input logic [ROB_BIT-1:0] t);
        issue_pollute = 1'b1; issue_reg_id = id; issue_rob_entry = t;
    endtask

    task automatic commit(input logic [REG_BIT-1:0] id, input logic [XLEN-1:0] d,
                          input logic [ROB_BIT-1:0] t);
        rob_commit = 1'b1; commit_reg_id = id; commit_reg_data = d; commit_rob_entry = t;
    endtask

    task automatic do_reset();
        idle();
        get_id = '0;
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        get_id = '0;
        rst_in = 1'b1;
        issue(5'd5, 4'd3);
        tick(); tick();
        rst_in = 1'b0;
        idle();
        rd(0, 5'd5); rd(1, 5'd0);
        value = {32'hAAAA_AAAA, 32'h5555_5555};
        settle();
        if ({has_dep, dep} !== 10'h000) begin $display("FAIL reset_dep: got %0h expected 0", {has_dep, dep}); fails++; end
        tests++;
        if (val !== 64'h0) begin $display("FAIL reset_val: got %0h expected 0", val); fails++; end
        tests++;
        if (get_rob_entry !== 8'h00) begin $display("FAIL reset_rob_entry: got %0h expected 0", get_rob_entry); fails++; end
        tests++;
        if ({ckpt_full, ckpt_ovf, ckpt_id} !== 4'b0000) begin
            $display("FAIL reset_ckpt: got %b expected 0000", {ckpt_full, ckpt_ovf, ckpt_id}); fails++;
        end
        tests++;
    endtask

    task automatic test_issue_commit();
        idle(); issue(5'd5, 4'd3); tick();
        idle(); rd(0, 5'd5); value[31:0] = 32'hDEAD; settle();
        if (has_dep[0] !== 1'b1 || dep[3:0] !== 4'd3) begin
            $display("FAIL issue_dep: got has_dep=%b dep=%0d expected 1/3", has_dep[0], dep[3:0]); fails++;
        end
        tests++;
        if (get_rob_entry[3:0] !== 4'd3 || val[31:0] !== 32'hDEAD) begin
            $display("FAIL issue_query: got tag=%0d val=%0h expected 3/dead", get_rob_entry[3:0], val[31:0]); fails++;
        end
        tests++;
        ready[0] = 1'b1; value[31:0] = 32'hBEEF; settle();
        if (has_dep[0] !== 1'b0 || val[31:0] !== 32'hBEEF) begin
            $display("FAIL rob_ready: got has_dep=%b val=%0h expected 0/beef", has_dep[0], val[31:0]); fails++;
        end
        tests++;
        ready[0] = 1'b0; value[31:0] = 32'hDEAD; commit(5'd5, 32'h1234, 4'd3); settle();
`ifdef REG_COMMIT_BYPASS_EN
        if (has_dep[0] !== 1'b0 || val[31:0] !== 32'h1234) begin
            $display("FAIL commit_same_cycle: got has_dep=%b val=%0h expected 0/1234", has_dep[0], val[31:0]); fails++;
        end
`else
        if (has_dep[0] !== 1'b1 || val[31:0] !== 32'hDEAD) begin
            $display("FAIL commit_same_cycle: got has_dep=%b val=%0h expected 1/dead", has_dep[0], val[31:0]); fails++;
        end
`endif
        tests++;
        tick(); idle(); settle();
        if (has_dep[0] !== 1'b0 || dep[3:0] !== 4'd0 || val[31:0] !== 32'h1234) begin
            $display("FAIL commit_visible: got has_dep=%b dep=%0d val=%0h expected 0/0/1234",
                     has_dep[0], dep[3:0], val[31:0]); fails++;
        end
        tests++;
    endtask

    task automatic test_reg_zero();
        idle(); issue(5'd0, 4'd5); commit(5'd0, 32'hFFFF, 4'd0); tick();
        idle(); rd(0, 5'd0); value[31:0] = 32'h7777; settle();
        if (has_dep[0] !== 1'b0 || val[31:0] !== 32'h0) begin
            $display("FAIL reg_zero: got has_dep=%b val=%0h expected 0/0", has_dep[0], val[31:0]); fails++;
        end
        tests++;
    endtask

    task automatic test_rename_override();
        idle(); issue(5'd7, 4'd2); tick();
        idle(); issue(5'd7, 4'd6); tick();
        idle(); commit(5'd7, 32'h77, 4'd2); tick();
        idle(); rd(1, 5'd7); settle();
        if (has_dep[1] !== 1'b1 || dep[7:4] !== 4'd6) begin
            $display("FAIL stale_commit: got has_dep=%b dep=%0d expected 1/6", has_dep[1], dep[7:4]); fails++;
        end
        tests++;
        ready[1] = 1'b1; value[63:32] = 32'h600D; settle();
        if (has_dep[1] !== 1'b0 || val[63:32] !== 32'h600D) begin
            $display("FAIL port1_ready: got has_dep=%b val=%0h expected 0/600d", has_dep[1], val[63:32]); fails++;
        end
        tests++;
        idle(); issue(5'd8, 4'd1); tick();
        idle(); commit(5'd8, 32'h88, 4'd1); issue(5'd8, 4'd9); tick();
        idle(); rd(0, 5'd8); settle();
        if (has_dep[0] !== 1'b1 || dep[3:0] !== 4'd9) begin
            $display("FAIL issue_over_commit: got has_dep=%b dep=%0d expected 1/9", has_dep[0], dep[3:0]); fails++;
        end
        tests++;
    endtask

    task automatic test_checkpoint_restore();
        do_reset();
        idle(); issue(5'd1, 4'd1); tick();
        idle(); ckpt_take = 1'b1; settle();
        if (ckpt_id !== 2'd0) begin $display("FAIL take_id: got %0d expected 0", ckpt_id); fails++; end
        tests++;
        tick();
        idle(); issue(5'd1, 4'd4); tick();
        idle(); issue(5'd2, 4'd5); tick();
        idle(); rd(0, 5'd1); rd(1, 5'd2); settle();
        if (dep !== 8'h54 || has_dep !== 2'b11) begin
            $display("FAIL pre_restore: got dep=%0h has_dep=%b expected 54/11", dep, has_dep); fails++;
        end
        tests++;
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
        issue(5'd3, 4'd2); ckpt_take = 1'b1;
        tick();
        idle(); settle();
        if (dep !== 8'h01 || has_dep !== 2'b01 || val[63:32] !== 32'h0) begin
            $display("FAIL restore_state: got dep=%0h has_dep=%b val1=%0h expected 01/01/0",
                     dep, has_dep, val[63:32]); fails++;
        end
        tests++;
        if (ckpt_id !== 2'd1 || dut.count !== 3'd1 || ckpt_full !== 1'b0) begin
            $display("FAIL restore_ptrs: got tail=%0d count=%0d full=%b expected 1/1/0",
                     ckpt_id, dut.count, ckpt_full); fails++;
        end
        tests++;
        rd(0, 5'd3); settle();
        if (has_dep[0] !== 1'b0) begin $display("FAIL restore_drops_issue: got %b expected 0", has_dep[0]); fails++; end
        tests++;
    endtask

    task automatic test_full_ovf();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); ckpt_take = 1'b1; settle();
            if (ckpt_id !== 2'(i)) begin $display("FAIL take_seq_id: got %0d expected %0d", ckpt_id, i); fails++; end
            tests++;
            tick();
        end
        idle(); settle();
        if ({ckpt_full, ckpt_ovf, ckpt_id} !== 4'b1000) begin
            $display("FAIL full_flag: got %b expected 1000", {ckpt_full, ckpt_ovf, ckpt_id}); fails++;
        end
        tests++;
        ckpt_take = 1'b1; tick();
        idle(); settle();
        if (ckpt_ovf !== 1'b1 || dut.count !== 3'd4 || ckpt_id !== 2'd0) begin
            $display("FAIL overflow: got ovf=%b count=%0d tail=%0d expected 1/4/0", ckpt_ovf, dut.count, ckpt_id); fails++;
        end
        tests++;
        ckpt_take = 1'b1; ckpt_release = 1'b1; settle();
        if (ckpt_id !== 2'd0) begin $display("FAIL wrap_take_id: got %0d expected 0", ckpt_id); fails++; end
        tests++;
        tick();
        idle(); settle();
        if (dut.count !== 3'd4 || ckpt_full !== 1'b1 || ckpt_id !== 2'd1 || ckpt_ovf !== 1'b1) begin
            $display("FAIL take_release: got count=%0d full=%b tail=%0d ovf=%b expected 4/1/1/1",
                     dut.count, ckpt_full, ckpt_id, ckpt_ovf); fails++;
        end
        tests++;
        ckpt_release = 1'b1;
        tick(); tick(); tick(); tick();
        idle(); settle();
        if (dut.count !== 3'd0 || ckpt_full !== 1'b0) begin
            $display("FAIL release_all: got count=%0d full=%b expected 0/0", dut.count, ckpt_full); fails++;
        end
        tests++;
    endtask

    task automatic test_ckpt_commit();
        do_reset();
        idle(); issue(5'd3, 4'd7); tick();
        idle(); ckpt_take = 1'b1; tick();
        idle(); commit(5'd3, 32'hABC, 4'd7); tick();
        idle(); ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; tick();
        idle(); rd(0, 5'd3); value[31:0] = 32'h5A5A; settle();
        if (has_dep[0] !== 1'b0 || dep[3:0] !== 4'd0 || val[31:0] !== 32'hABC) begin
            $display("FAIL ckpt_commit_clear: got has_dep=%b dep=%0d val=%0h expected 0/0/abc",
                     has_dep[0], dep[3:0], val[31:0]); fails++;
        end
        tests++;
        idle(); issue(5'd4, 4'd2); tick();
        idle(); ckpt_take = 1'b1; settle();
        if (ckpt_id !== 2'd1) begin $display("FAIL take_after_restore: got %0d expected 1", ckpt_id); fails++; end
        tests++;
        tick();
        idle(); ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; commit(5'd4, 32'h44, 4'd2); tick();
        idle(); rd(1, 5'd4); settle();
        if (has_dep[1] !== 1'b0 || val[63:32] !== 32'h44 || dut.count !== 3'd2) begin
            $display("FAIL restore_with_commit: got has_dep=%b val=%0h count=%0d expected 0/44/2",
                     has_dep[1], val[63:32], dut.count); fails++;
        end
        tests++;
        idle(); issue(5'd6, 4'd3); ckpt_take = 1'b1; tick();
        idle(); issue(5'd6, 4'd8); tick();
        idle(); rd(0, 5'd6); settle();
        if (dep[3:0] !== 4'd8) begin $display("FAIL young_rename: got %0d expected 8", dep[3:0]); fails++; end
        tests++;
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; tick();
        idle(); settle();
        if (dep[3:0] !== 4'd3 || has_dep[0] !== 1'b1) begin
            $display("FAIL take_includes_issue: got dep=%0d has_dep=%b expected 3/1", dep[3:0], has_dep[0]); fails++;
        end
        tests++;
    endtask

    task automatic test_clear_rdy();
        do_reset();
        idle(); commit(5'd10, 32'h11, 4'd0); tick();
        idle(); ckpt_take = 1'b1; tick();
        idle(); rob_clear_up = 1'b1; issue(5'd9, 4'd4); commit(5'd10, 32'h55, 4'd0); tick();
        idle(); rd(0, 5'd9); rd(1, 5'd10); value = {32'h1, 32'h2}; settle();
        if (has_dep !== 2'b00 || val[63:32] !== 32'h11 || val[31:0] !== 32'h0) begin
            $display("FAIL clear_state: got has_dep=%b val=%0h expected 00/00000011_00000000", has_dep, val); fails++;
        end
        tests++;
        if (dut.count !== 3'd0 || ckpt_id !== 2'd0) begin
            $display("FAIL clear_ptrs: got count=%0d tail=%0d expected 0/0", dut.count, ckpt_id); fails++;
        end
        tests++;
        idle(); rdy_in = 1'b0; commit(5'd11, 32'h99, 4'd0); issue(5'd12, 4'd1); ckpt_take = 1'b1; tick();
        idle(); rd(0, 5'd11); rd(1, 5'd12); settle();
        if (val[31:0] !== 32'h0 || has_dep !== 2'b00 || ckpt_id !== 2'd0 || dut.count !== 3'd0) begin
            $display("FAIL stall_hold: got val0=%0h has_dep=%b tail=%0d count=%0d expected 0/00/0/0",
                     val[31:0], has_dep, ckpt_id, dut.count); fails++;
        end
        tests++;
        idle(); issue(5'd13, 4'd5); tick();
        idle(); rdy_in = 1'b0; commit(5'd13, 32'h13, 4'd5); tick();
        idle(); rd(0, 5'd13); settle();
        if (has_dep[0] !== 1'b1 || dep[3:0] !== 4'd5) begin
            $display("FAIL stall_commit: got has_dep=%b dep=%0d expected 1/5", has_dep[0], dep[3:0]); fails++;
        end
        tests++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_issue_commit();
        test_reg_zero();
        test_rename_override();
        test_checkpoint_restore();
        test_full_ovf();
        test_ckpt_commit();
        test_clear_rdy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
